// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALUOp encodings and the IF/ID
// register layout used by the fetch stage.
package mips_pkg;

   localparam logic [5:0]  OP_RTYPE  = 6'b000000;
   localparam logic [5:0]  OP_LW     = 6'b100011;
   localparam logic [5:0]  OP_SW     = 6'b101011;
   localparam logic [5:0]  OP_BEQ    = 6'b000100;

   // sll $0,$0,0 -- also what a flushed IF/ID slot presents downstream.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_e;

   typedef enum logic [1:0] {
      FETCH_ADVANCE,
      FETCH_HOLD,
      FETCH_REDIRECT
   } fetch_sel_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

endpackage : mips_pkg

// File: rtl/instr_fetch_stage_if.sv
// Control, loader and IF/ID signals between the fetch stage and the rest of
// the pipeline (master = pipeline/loader side, slave = fetch stage).
interface instr_fetch_stage_if #(
   parameter int IMEM_DEPTH = 64
);
   localparam int AW = $clog2(IMEM_DEPTH);

   logic          stall;
   logic          branch_taken;
   logic [31:0]   branch_target;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [31:0]   imem_wdata;

   logic [31:0]   pc_out;
   logic [31:0]   if_id_instr;
   logic [5:0]    if_id_op;
   logic [31:0]   if_id_pc4;
   logic          if_id_valid;

   modport master (
      output stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
      input  pc_out, if_id_instr, if_id_op, if_id_pc4, if_id_valid
   );

   modport slave (
      input  stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
      output pc_out, if_id_instr, if_id_op, if_id_pc4, if_id_valid
   );

endinterface : instr_fetch_stage_if

// File: rtl/instr_mem.sv
// Word-addressed instruction memory: one synchronous write port for the
// program loader, one combinational read port for fetch.
module instr_mem #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // NOTE: the array has no reset -- program contents must survive rst_n, and
   // clearing a RAM on reset would also stop it mapping onto memory macros.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read sees the pre-edge contents, so a same-cycle write is visible next cycle.
   assign rdata = mem[raddr];

endmodule : instr_mem

// File: rtl/instr_fetch_stage.sv
// MIPS IF stage: PC register, instruction memory and the IF/ID pipeline
// register, with branch redirect (highest priority) and load-use stall.
module instr_fetch_stage
   import mips_pkg::*;
#(
   parameter int          IMEM_DEPTH = 64,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst_n,
   instr_fetch_stage_if.slave  bus
);

   localparam int AW = $clog2(IMEM_DEPTH);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] fetch_word;
   if_id_t      if_id_q, if_id_d;
   fetch_sel_e  sel;

   assign pc_plus4 = pc_q + 32'd4;

   instr_mem #(
      .DEPTH (IMEM_DEPTH)
   ) u_imem (
      .clk   (clk),
      .we    (bus.imem_we),
      .waddr (bus.imem_waddr),
      .wdata (bus.imem_wdata),
      .raddr (pc_q[AW+1:2]),
      .rdata (fetch_word)
   );

   // NOTE: every always_comb output gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      sel = FETCH_ADVANCE;
      if (bus.branch_taken) begin
         sel = FETCH_REDIRECT;
      end else if (bus.stall) begin
         sel = FETCH_HOLD;
      end
   end

   always_comb begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
      unique case (sel)
         FETCH_REDIRECT: begin
            pc_d    = bus.branch_target & ~32'h3;
            if_id_d = IF_ID_BUBBLE;
         end
         FETCH_HOLD: begin
            pc_d    = pc_q;
            if_id_d = if_id_q;
         end
         default: begin
            pc_d          = pc_plus4;
            if_id_d.instr = fetch_word;
            if_id_d.pc4   = pc_plus4;
            if_id_d.valid = 1'b1;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         if_id_q <= IF_ID_BUBBLE;
      end else begin
         pc_q    <= pc_d;
         if_id_q <= if_id_d;
      end
   end

   assign bus.pc_out      = pc_q;
   assign bus.if_id_instr = if_id_q.instr;
   assign bus.if_id_op    = if_id_q.instr[31:26];
   assign bus.if_id_pc4   = if_id_q.pc4;
   assign bus.if_id_valid = if_id_q.valid;

endmodule : instr_fetch_stage

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: the driver advances a behavioural
// model and queues expected IF/ID state; a monitor compares after each edge.
module tb_instr_fetch_stage;
   import mips_pkg::*;

   localparam int DEPTH = 64;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic rst_w_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   exp_t q[$];
   exp_t qw[$];

   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;

   always #5 clk = ~clk;

   instr_fetch_stage_if #(.IMEM_DEPTH(DEPTH)) bus ();
   instr_fetch_stage_if #(.IMEM_DEPTH(DEPTH)) bus_w ();

   instr_fetch_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   instr_fetch_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk   (clk),
      .rst_n (rst_w_n),
      .bus   (bus_w)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of the stage, phrased directly from the fetch rules.
   task automatic model_edge(input logic st, input logic br, input logic [31:0] tgt,
                             input logic we, input logic [5:0] wa, input logic [31:0] wd);
      if (br) begin
         m_pc    = (tgt / 4) * 4;
         m_instr = 32'h0;
         m_pc4   = 32'h0;
         m_valid = 1'b0;
      end else if (!st) begin
         m_instr = m_mem[(m_pc / 4) % DEPTH];
         m_pc4   = m_pc + 32'd4;
         m_valid = 1'b1;
         m_pc    = m_pc + 32'd4;
      end
      if (we) m_mem[wa] = wd;
   endtask

   // Called at a negedge: drive one cycle, queue the post-edge state, move to next negedge.
   task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                       input logic we, input logic [5:0] wa, input logic [31:0] wd);
      bus.stall         = st;
      bus.branch_taken  = br;
      bus.branch_target = tgt;
      bus.imem_we       = we;
      bus.imem_waddr    = wa;
      bus.imem_wdata    = wd;
      model_edge(st, br, tgt, we, wa, wd);
      q.push_back('{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid});
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
   endtask

   task automatic apply_reset_midcycle();
      #2;
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      q.push_back('{pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0});
      rst_n = 1'b0;
   endtask

   // Monitor: compares whenever the stage presents a new state (edge or async reset).
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or negedge rst_n);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("pc_out", bus.pc_out, e.pc);
            check("if_id_instr", bus.if_id_instr, e.instr);
            check("if_id_op", {26'h0, bus.if_id_op}, {26'h0, e.instr[31:26]});
            check("if_id_pc4", bus.if_id_pc4, e.pc4);
            check("if_id_valid", {31'h0, bus.if_id_valid}, {31'h0, e.valid});
         end
         if (qw.size() > 0) begin
            e = qw.pop_front();
            check("wrap_pc_out", bus_w.pc_out, e.pc);
            check("wrap_if_id_pc4", bus_w.if_id_pc4, e.pc4);
            check("wrap_if_id_valid", {31'h0, bus_w.if_id_valid}, {31'h0, e.valid});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] w, p;
      bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
      bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = 32'h0;
      bus_w.stall = 1'b0; bus_w.branch_taken = 1'b0; bus_w.branch_target = 32'h0;
      bus_w.imem_we = 1'b0; bus_w.imem_waddr = '0; bus_w.imem_wdata = 32'h0;

      // Power-on reset, checked asynchronously before any clock edge.
      apply_reset_midcycle();

      // Load the program while held in reset.
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         case (i)
            0:       w = 32'h8C01_0004;
            1:       w = 32'h8C02_0008;
            2:       w = 32'h0022_1820;
            3:       w = 32'hAC03_000C;
            default: w = $urandom;
         endcase
         bus.imem_we = 1'b1; bus.imem_waddr = 6'(i); bus.imem_wdata = w;
         m_mem[i] = w;
      end
      @(negedge clk);
      bus.imem_we = 1'b0;
      rst_n = 1'b1;

      // Sequential fetch, then stall for 2 cycles with a concurrent loader write.
      run(2);
      step(1'b1, 1'b0, 32'h0, 1'b1, 6'd6, 32'h1234_5678);
      step(1'b1, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
      run(2);
      // Branch flush, then fetch imem[5] and the freshly loaded imem[6].
      step(1'b0, 1'b1, 32'h0000_0014, 1'b0, 6'd0, 32'h0);
      run(2);
      // Branch beats stall; target low bits ignored.
      step(1'b1, 1'b1, 32'h0000_0007, 1'b0, 6'd0, 32'h0);
      run(1);
      // Wrap: imem[63] then imem[0] via PC=0x100.
      step(1'b0, 1'b1, 32'h0000_00FC, 1'b0, 6'd0, 32'h0);
      run(2);
      // Same-cycle write to the word being fetched returns the old data.
      p = m_pc;
      step(1'b0, 1'b0, 32'h0, 1'b1, 6'((p / 4) % DEPTH), 32'hCAFE_F00D);
      step(1'b0, 1'b1, p, 1'b0, 6'd0, 32'h0);
      run(1);

      // Randomised phase.
      for (int i = 0; i < 200; i++) begin
         step($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom,
              $urandom_range(2) == 0, 6'($urandom), $urandom);
      end

      // Async reset with a valid instruction in IF/ID; memory must survive.
      run(1);
      apply_reset_midcycle();
      @(negedge clk);
      rst_n = 1'b1;
      run(4);

      // Second instance: RESET_PC at the top of the address space wraps to 0.
      bus.stall = 1'b1;
      qw.push_back('{pc: 32'hFFFF_FFFC, instr: 32'h0, pc4: 32'h0, valid: 1'b0});
      @(negedge clk);
      rst_w_n = 1'b1;
      qw.push_back('{pc: 32'h0000_0000, instr: 32'h0, pc4: 32'h0, valid: 1'b1});
      @(negedge clk);
      qw.push_back('{pc: 32'h0000_0004, instr: 32'h0, pc4: 32'h4, valid: 1'b1});
      @(negedge clk);
      @(negedge clk);

      check("scoreboard_drained", q.size() + qw.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_instr_fetch_stage

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Front end of the pipelined MIPS datapath.
- Owns the PC and a word-addressed instruction memory, and registers the fetched instruction into the IF/ID pipeline register.
- Drives the 6-bit opcode field into the control-unit decoder, and accepts back the resolved branch decision (Branch AND Zero) with its target.
- Also provides a stall hold and a loader write port for test programs.

Parameters:
- IMEM_DEPTH, 64, number of 32-bit instruction words; must be a power of two.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold PC and IF/ID register (load-use hazard)
- branch_taken  in  1  resolved beq taken, from EX (Branch & Zero)
- branch_target  in  32  byte address of the taken branch
- imem_we  in  1  loader write enable
- imem_waddr  in  log2(IMEM_DEPTH)  loader word index
- imem_wdata  in  32  loader instruction word
- pc_out  out  32  current fetch PC
- if_id_instr  out  32  registered instruction
- if_id_op  out  6  if_id_instr[31:26], feeds control decoder
- if_id_pc4  out  32  registered PC+4 of that instruction
- if_id_valid  out  1  1 = real instruction, 0 = bubble

Behaviour:
- Reset (async, rst_n=0):
  - PC = RESET_PC; if_id_instr = 0; if_id_pc4 = 0; if_id_valid = 0.
  - Memory contents are not cleared.
  - Mid-run reset drops the in-flight instruction immediately, without waiting for a clock edge.
- Fetch:
  - Combinational read imem[PC[log2(IMEM_DEPTH)+1:2]].
  - Address wraps modulo IMEM_DEPTH words; PC[1:0] are ignored.
  - Latency is 1 cycle: the instruction at PC appears on if_id_instr on the next rising edge.
- Per-edge priority (highest first): branch_taken, then stall, then normal.
  - branch_taken=1:
    - PC <= {branch_target[31:2], 2'b00}.
    - IF/ID flushed: instr=0 (sll $0 nop, op 000000), valid=0, pc4=0.
    - This overrides stall in the same cycle.
  - stall=1 (no branch): PC, if_id_instr, if_id_pc4 and if_id_valid all hold.
  - Normal:
    - PC <= PC+4, wrapping modulo 2^32.
    - if_id_instr <= fetched word; if_id_pc4 <= PC+4; if_id_valid <= 1.
- if_id_op is always exactly if_id_instr[31:26]. A bubble therefore presents opcode 000000 (R-type nop, writes $0).
- Loader:
  - imem_we writes imem_wdata at imem_waddr on the rising edge. This is independent of stall and branch.
  - Same-cycle read of the same word returns the old data; the new data is visible from the next cycle.
- PC+4 is computed 32-bit unsigned. The carry is discarded at 32'hFFFF_FFFC, giving 0.
- First cycle after reset release: if_id_valid stays 0 until the first non-stalled, non-branch edge.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100
  - NOP_INSTR=32'h0
  - the ALUOp encodings (00/01/10), shared with the control decoder.
- One sub-module: instr_mem.
  - Parameterised word array with 1 synchronous write port and 1 combinational read port.
  - The top level holds the PC and IF/ID registers plus the priority logic.

Test Plan:
- Sequential fetch:
  - Stimulus: load imem[0..3] = 8C010004, 8C020008, 00221820, AC03000C; release reset; run.
  - Response: if_id_instr shows those words on cycles 1-4; if_id_op = 23, 23, 00, 2B (hex); if_id_pc4 = 4, 8, C, 10; pc_out = 4, 8, C, 10, 14.
- Stall hold:
  - Stimulus: at PC=8, assert stall for 2 cycles.
  - Response: pc_out stays 8; if_id_instr stays 8C020008 with if_id_valid=1; on release, the next edge gives if_id_instr=00221820 and PC=C.
- Branch flush:
  - Stimulus: branch_taken=1, branch_target=32'h14 while PC=C.
  - Response: next edge gives PC=14, if_id_instr=0, if_id_op=0, valid=0; the following edge gives the word at imem[5] with pc4=18.
- Branch vs stall:
  - Stimulus: stall=1 and branch_taken=1 in the same cycle, target=32'h07.
  - Response: the branch wins; PC=4 (low bits cleared); IF/ID flushed.
- Wrap:
  - Stimulus: IMEM_DEPTH=64; branch to 32'h0000_00FC, then 32'h100.
  - Response: fetches imem[63], then imem[0]. With RESET_PC=32'hFFFF_FFFC, the first advance gives PC=0.
- Async reset mid-run:
  - Stimulus: rst_n low between clock edges while if_id_valid=1.
  - Response: all outputs reach reset values immediately (PC=RESET_PC, valid=0); memory contents are retained.
